// File: rtl/fll_cfg_sequencer.sv
// FLL configuration sequencer: takes one read/write command at a time, runs the 4-phase
// req/ack handshake towards the FLL config port, optionally waits for FLL lock after a write,
// and returns exactly one response with read data and timeout status.
module fll_cfg_sequencer #(
  parameter int unsigned ACK_TIMEOUT    = 255,
  parameter int unsigned LOCK_TIMEOUT   = 4095,
  parameter logic [1:0]  LOCK_WAIT_ADDR = 2'd1,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wrn_i,
  input  logic [1:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic        cmd_lock_wait_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic        busy_o,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  input  logic        fll_lock_i
);

  localparam int unsigned MaxTo0     = (ACK_TIMEOUT > LOCK_TIMEOUT) ? ACK_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned MaxTimeout = (MaxTo0 > 0) ? MaxTo0 : 1;
  localparam int unsigned CntW       = $clog2(MaxTimeout + 1);

  // Timeout fires on the edge where the count would reach the limit, so a wait lasts
  // exactly TIMEOUT cycles.
  localparam logic [CntW-1:0] AckLimit  = CntW'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0] LockLimit = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax    = '1;

  localparam logic [1:0] ErrOk   = 2'd0;
  localparam logic [1:0] ErrAck  = 2'd1;
  localparam logic [1:0] ErrLock = 2'd2;

  typedef enum logic [2:0] {StIdle, StReq, StAckLo, StLock, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              lock_en_q, lock_en_d;
  logic              wrn_q, wrn_d;
  logic [1:0]        add_q, add_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              req_q, req_d;
  logic              ready_q, ready_d;

  logic [SYNC_STAGES-1:0] ack_sync_q, lock_sync_q;
  logic                   ack, lock;
  logic                   ack_expired, lock_expired;

  // Synchronise the asynchronous FLL ack and lock inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], fll_ack_i};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], fll_lock_i};
    end
  end

  assign ack  = ack_sync_q[SYNC_STAGES-1];
  assign lock = lock_sync_q[SYNC_STAGES-1];

  assign ack_expired  = (ACK_TIMEOUT != 0) && (cnt_q >= AckLimit);
  assign lock_expired = (LOCK_TIMEOUT != 0) && (cnt_q >= LockLimit);

  // Next-state, captured command/response fields and timeout counter.
  always_comb begin
    state_d   = state_q;
    lock_en_d = lock_en_q;
    wrn_d     = wrn_q;
    add_d     = add_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && ready_q) begin
          wrn_d     = cmd_wrn_i;
          add_d     = cmd_addr_i;
          data_d    = cmd_wdata_i;
          lock_en_d = cmd_lock_wait_i && !cmd_wrn_i && (cmd_addr_i == LOCK_WAIT_ADDR);
          rdata_d   = '0;
          err_d     = ErrOk;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (ack) begin
          rdata_d = wrn_q ? fll_r_data_i : '0;
          state_d = StAckLo;
        end else if (ack_expired) begin
          rdata_d = '0;
          err_d   = ErrAck;
          state_d = StAckLo;
        end
      end
      StAckLo: begin
        if (!ack) begin
          // A failed handshake never proceeds to the lock wait.
          state_d = (lock_en_q && (err_q == ErrOk)) ? StLock : StResp;
        end else if (ack_expired) begin
          err_d   = ErrAck;
          state_d = StResp;
        end
      end
      StLock: begin
        if (lock) begin
          state_d = StResp;
        end else if (lock_expired) begin
          err_d   = ErrLock;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == StReq) || (state_q == StAckLo) || (state_q == StLock)) &&
                 (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end

    req_d   = (state_d == StReq);
    ready_d = (state_d == StIdle);
  end

  // State and registered outputs; ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      lock_en_q <= 1'b0;
      wrn_q     <= 1'b0;
      add_q     <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      err_q     <= ErrOk;
      req_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lock_en_q <= lock_en_d;
      wrn_q     <= wrn_d;
      add_q     <= add_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      req_q     <= req_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != StIdle);
  assign fll_req_o   = req_q;
  assign fll_wrn_o   = wrn_q;
  assign fll_add_o   = add_q;
  assign fll_data_o  = data_q;

endmodule

// File: tb/tb_fll_cfg_sequencer.sv
// Directed self-checking bench for fll_cfg_sequencer with a behavioural FLL model.
// A second instance with a short lock timeout covers the lock-timeout case.
module tb_fll_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_wrn_i, cmd_lock_wait_i;
  logic [1:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        cmd_ready_o, rsp_valid_o, busy_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;
  logic        fll_req_o, fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o;
  logic        fll_ack_i, fll_lock_i;
  logic [31:0] fll_r_data_i;

  logic        lt_cmd_ready, lt_rsp_valid, lt_busy, lt_fll_req, lt_fll_wrn;
  logic [31:0] lt_rsp_rdata, lt_fll_data;
  logic [1:0]  lt_rsp_err, lt_fll_add;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int t_acc, t_rsp, t_ack_fall, t_lock;

  // FLL model controls
  int          ack_delay = 0;
  logic        ack_never = 1'b0;
  logic        lock_arm  = 1'b0;
  logic [31:0] model_rdata = '0;
  int          ack_cnt  = 0;
  int          lock_cnt = 0;

  // Monitor state
  logic [1:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  int          req_rises = 0;
  int          rsp_hs = 0;
  int          hold_bad = 0;
  logic        req_prev = 1'b0;

  fll_cfg_sequencer #(
    .ACK_TIMEOUT   (8),
    .LOCK_TIMEOUT  (64),
    .LOCK_WAIT_ADDR(2'd1),
    .SYNC_STAGES   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_wrn_i      (cmd_wrn_i),
    .cmd_addr_i     (cmd_addr_i),
    .cmd_wdata_i    (cmd_wdata_i),
    .cmd_lock_wait_i(cmd_lock_wait_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .busy_o         (busy_o),
    .fll_req_o      (fll_req_o),
    .fll_wrn_o      (fll_wrn_o),
    .fll_add_o      (fll_add_o),
    .fll_data_o     (fll_data_o),
    .fll_ack_i      (fll_ack_i),
    .fll_r_data_i   (fll_r_data_i),
    .fll_lock_i     (fll_lock_i)
  );

  fll_cfg_sequencer #(
    .ACK_TIMEOUT   (8),
    .LOCK_TIMEOUT  (16),
    .LOCK_WAIT_ADDR(2'd1),
    .SYNC_STAGES   (2)
  ) dut_lt (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (lt_cmd_ready),
    .cmd_wrn_i      (cmd_wrn_i),
    .cmd_addr_i     (cmd_addr_i),
    .cmd_wdata_i    (cmd_wdata_i),
    .cmd_lock_wait_i(cmd_lock_wait_i),
    .rsp_valid_o    (lt_rsp_valid),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (lt_rsp_rdata),
    .rsp_err_o      (lt_rsp_err),
    .busy_o         (lt_busy),
    .fll_req_o      (lt_fll_req),
    .fll_wrn_o      (lt_fll_wrn),
    .fll_add_o      (lt_fll_add),
    .fll_data_o     (lt_fll_data),
    .fll_ack_i      (fll_ack_i),
    .fll_r_data_i   (fll_r_data_i),
    .fll_lock_i     (fll_lock_i)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FLL model: ack ack_delay cycles after req, drop ack when req drops, optional delayed lock.
  initial begin : fll_model
    fll_ack_i    = 1'b0;
    fll_r_data_i = '0;
    fll_lock_i   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (lock_cnt > 0) begin
        lock_cnt--;
        if (lock_cnt == 0) begin
          fll_lock_i = 1'b1;
          t_lock     = cyc;
        end
      end
      if (!fll_ack_i) begin
        if (fll_req_o && !ack_never) begin
          if (ack_cnt >= ack_delay) begin
            fll_ack_i    = 1'b1;
            fll_r_data_i = model_rdata;
            ack_cnt      = 0;
          end else begin
            ack_cnt++;
          end
        end else begin
          ack_cnt = 0;
        end
      end else if (!fll_req_o) begin
        fll_ack_i  = 1'b0;
        t_ack_fall = cyc;
        if (lock_arm) begin
          lock_cnt = 20;
          lock_arm = 1'b0;
        end
      end
    end
  end

  // Counts req pulses and response handshakes; flags address/data moving during a handshake.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (fll_req_o && !req_prev) req_rises++;
      req_prev = fll_req_o;
      if (rsp_valid_o && rsp_ready_i) rsp_hs++;
      if ((fll_req_o || fll_ack_i) && ((fll_add_o !== exp_addr) || (fll_data_o !== exp_data)))
        hold_bad++;
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic wrn, input logic [1:0] addr, input logic [31:0] wdata,
                        input logic lw);
    int n = 0;
    while (!cmd_ready_o && n < 300) begin
      step();
      n++;
    end
    check("cmd_ready_wait", cmd_ready_o, 1'b1);
    cmd_valid_i     = 1'b1;
    cmd_wrn_i       = wrn;
    cmd_addr_i      = addr;
    cmd_wdata_i     = wdata;
    cmd_lock_wait_i = lw;
    step();
    t_acc       = cyc;
    cmd_valid_i = 1'b0;
  endtask

  // Waits for the response, samples it, and lets the handshake edge pass (rsp_ready_i high).
  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] er);
    int n = 0;
    while (!rsp_valid_o && n < 300) begin
      step();
      n++;
    end
    check("rsp_seen", rsp_valid_o, 1'b1);
    rd    = rsp_rdata_o;
    er    = rsp_err_o;
    t_rsp = cyc;
    step();
  endtask

  logic [31:0] rd;
  logic [1:0]  er;
  int          n;
  int          bad;

  initial begin : main
    rst_n           = 1'b0;
    cmd_valid_i     = 1'b0;
    cmd_wrn_i       = 1'b0;
    cmd_addr_i      = '0;
    cmd_wdata_i     = '0;
    cmd_lock_wait_i = 1'b0;
    rsp_ready_i     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req", fll_req_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", cmd_ready_o, 1'b1);

    // Read addr 2, ack after 3 cycles
    ack_delay   = 3;
    model_rdata = 32'hDEAD_BEEF;
    exp_addr    = 2'd2;
    exp_data    = '0;
    do_cmd(1'b1, 2'd2, 32'h0, 1'b0);
    wait_rsp(rd, er);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", er, 2'd0);
    // 6 edges for the handshake plus 3 of ack delay, counted after the accept edge
    check("rd_latency", t_rsp - t_acc, 9);
    repeat (2) step();
    check("rd_req_pulses", req_rises, 1);
    check("rd_rsp_count", rsp_hs, 1);
    check("rd_hold", hold_bad, 0);

    // Write addr 1 with lock wait; lock rises 20 cycles after ack falls
    lock_arm = 1'b1;
    exp_addr = 2'd1;
    exp_data = 32'h0000_1234;
    do_cmd(1'b0, 2'd1, 32'h0000_1234, 1'b1);
    wait_rsp(rd, er);
    check("lw_data", rd, 32'h0);
    check("lw_err", er, 2'd0);
    check("lw_lock_to_rsp", t_rsp - t_lock, 3);
    check("lw_ackfall_to_rsp", t_rsp - t_ack_fall, 23);
    check("lw_hold", hold_bad, 0);
    fll_lock_i = 1'b0;

    // Same write without lock wait
    do_cmd(1'b0, 2'd1, 32'h0000_1234, 1'b0);
    wait_rsp(rd, er);
    check("nolw_err", er, 2'd0);
    check("nolw_data", rd, 32'h0);
    check("nolw_latency", t_rsp - t_acc, 9);

    // FLL never acks: req lasts ACK_TIMEOUT cycles, err=1
    ack_never = 1'b1;
    exp_addr  = 2'd0;
    exp_data  = '0;
    do_cmd(1'b1, 2'd0, 32'h0, 1'b0);
    n = 0;
    while (fll_req_o && n < 50) begin
      step();
      n++;
    end
    check("to_req_len", n, 8);
    wait_rsp(rd, er);
    check("to_err", er, 2'd1);
    check("to_data", rd, 32'h0);
    ack_never   = 1'b0;
    model_rdata = 32'hA5A5_0001;
    exp_addr    = 2'd3;
    do_cmd(1'b1, 2'd3, 32'h0, 1'b0);
    wait_rsp(rd, er);
    check("after_to_err", er, 2'd0);
    check("after_to_data", rd, 32'hA5A5_0001);

    // Lock never rises: short-timeout instance reports err=2 16 cycles after LOCK entry
    ack_delay = 0;
    exp_addr  = 2'd1;
    exp_data  = 32'h0000_5678;
    do_cmd(1'b0, 2'd1, 32'h0000_5678, 1'b1);
    n = 0;
    while (!lt_rsp_valid && n < 200) begin
      step();
      n++;
    end
    check("lt_rsp_seen", lt_rsp_valid, 1'b1);
    check("lt_err", lt_rsp_err, 2'd2);
    check("lt_data", lt_rsp_rdata, 32'h0);
    // 3 edges to sync ack low and enter LOCK, then 16 of timeout
    check("lt_ackfall_to_rsp", cyc - t_ack_fall, 19);
    fll_lock_i = 1'b1;
    wait_rsp(rd, er);
    check("lt_main_err", er, 2'd0);
    fll_lock_i = 1'b0;

    // Response backpressure with a held new command
    rsp_ready_i = 1'b0;
    model_rdata = 32'h0BAD_F00D;
    exp_addr    = 2'd2;
    exp_data    = '0;
    do_cmd(1'b1, 2'd2, 32'h0, 1'b0);
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      step();
      n++;
    end
    check("bp_rsp_seen", rsp_valid_o, 1'b1);
    check("bp_data", rsp_rdata_o, 32'h0BAD_F00D);
    exp_addr        = 2'd1;
    model_rdata     = 32'h1111_2222;
    cmd_valid_i     = 1'b1;
    cmd_wrn_i       = 1'b1;
    cmd_addr_i      = 2'd1;
    cmd_wdata_i     = '0;
    cmd_lock_wait_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!rsp_valid_o || (rsp_rdata_o !== 32'h0BAD_F00D) || (rsp_err_o !== 2'd0) ||
          cmd_ready_o || !busy_o)
        bad++;
    end
    check("bp_stable", bad, 0);
    rsp_ready_i = 1'b1;
    step();
    check("bp_hs_valid", rsp_valid_o, 1'b0);
    check("bp_hs_busy", busy_o, 1'b0);
    check("bp_hs_ready", cmd_ready_o, 1'b1);
    step();
    check("bp_accept_busy", busy_o, 1'b1);
    check("bp_accept_ready", cmd_ready_o, 1'b0);
    cmd_valid_i = 1'b0;
    wait_rsp(rd, er);
    check("bp_next_data", rd, 32'h1111_2222);
    check("bp_next_err", er, 2'd0);

    // Reset while in REQ
    ack_never = 1'b1;
    exp_addr  = 2'd3;
    do_cmd(1'b1, 2'd3, 32'h0, 1'b0);
    repeat (3) step();
    check("mid_req_high", fll_req_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", fll_req_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_ready", cmd_ready_o, 1'b0);
    check("mid_rst_lt_req", lt_fll_req, 1'b0);
    check("mid_rst_lt_busy", lt_busy, 1'b0);
    ack_never = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("mid_post_ready", cmd_ready_o, 1'b1);
    check("mid_post_lt_ready", lt_cmd_ready, 1'b1);
    ack_delay   = 1;
    model_rdata = 32'hCAFE_0042;
    exp_addr    = 2'd2;
    do_cmd(1'b1, 2'd2, 32'h0, 1'b0);
    wait_rsp(rd, er);
    check("mid_fresh_data", rd, 32'hCAFE_0042);
    check("mid_fresh_err", er, 2'd0);
    check("final_hold", hold_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
